// File: rtl/idle_rx_detector.sv
// idle_rx_detector: counts consecutive all-lane Idle symbol times and flags done at TARGET; IDLE_SKP_TOLERATE_EN makes SKP ordered sets transparent
//   clk, rst                   clock and synchronous active-high reset
//   det_enable, det_clr        arm detection / restart detection
//   rx_valid, rx_data          one symbol time per valid cycle, lane i at rx_data[i*SYM_W +: SYM_W]
//   rx_lane_mask               active lanes of the configured link width
//   rx_is_os, rx_is_skp        ordered-set block marker and SKP qualifier
//   idle_cnt                   consecutive Idle count, saturating at TARGET
//   idle_rcvd_done             sticky level once TARGET Idles are received
//   nonidle_seen               one-cycle pulse when a non-Idle symbol time arrives
module idle_rx_detector #(
  parameter int LANES     = 16,
  parameter int SYM_W     = 8,
  parameter int TARGET    = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   det_enable,
  input  logic                   det_clr,
  input  logic                   rx_valid,
  input  logic [LANES*SYM_W-1:0] rx_data,
  input  logic [LANES-1:0]       rx_lane_mask,
  input  logic                   rx_is_os,
  input  logic                   rx_is_skp,
  output logic [CNT_WIDTH-1:0]   idle_cnt,
  output logic                   idle_rcvd_done,
  output logic                   nonidle_seen
);
  if (2**CNT_WIDTH <= TARGET) begin : g_cnt_width_check
    $error("idle_rx_detector: 2**CNT_WIDTH must exceed TARGET");
  end
  localparam logic [CNT_WIDTH-1:0] TGT = CNT_WIDTH'(TARGET);
  typedef enum logic [1:0] {OFF, COUNT, DONE} state_e;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d, nis_q, nis_d;
  logic [LANES-1:0]     lane_nz;
  logic                 is_idle, skp_hold;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_nz[i] = |rx_data[i*SYM_W +: SYM_W];
  end
  assign is_idle = !rx_is_os && |rx_lane_mask && !(|(lane_nz & rx_lane_mask));
`ifdef IDLE_SKP_TOLERATE_EN
  assign skp_hold = rx_is_os && rx_is_skp;
`else
  logic unused_skp;
  assign unused_skp = rx_is_skp;
  assign skp_hold   = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    nis_d   = 1'b0;
    if (det_clr) begin
      state_d = det_enable ? COUNT : OFF;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (!det_enable) begin
      state_d = OFF;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (state_q == OFF) begin
      state_d = COUNT;
    end else if (rx_valid && !skp_hold && !is_idle) begin
      // done is sticky, so the count stays pinned at TARGET once reached
      nis_d = 1'b1;
      cnt_d = (state_q == DONE) ? TGT : '0;
    end else if (rx_valid && !skp_hold && state_q == COUNT) begin
      cnt_d   = cnt_q + 1'b1;
      done_d  = (cnt_d == TGT);
      state_d = done_d ? DONE : COUNT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      nis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      nis_q   <= nis_d;
    end
  end
  assign idle_cnt       = cnt_q;
  assign idle_rcvd_done = done_q;
  assign nonidle_seen   = nis_q;
endmodule

// File: tb/tb_idle_rx_detector.sv
// tb_idle_rx_detector: directed stimulus checked cycle-by-cycle against a behavioural Idle-run model
module tb_idle_rx_detector;
  localparam int LANES = 16, SYM_W = 8, TARGET = 8, CW = 4;
`ifdef IDLE_SKP_TOLERATE_EN
  localparam bit SKP_TOL = 1'b1;
`else
  localparam bit SKP_TOL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, det_enable = 1'b0, det_clr = 1'b0;
  logic rx_valid = 1'b0, rx_is_os = 1'b0, rx_is_skp = 1'b0;
  logic [LANES*SYM_W-1:0] rx_data = '0;
  logic [LANES-1:0] rx_lane_mask = '1;
  logic [CW-1:0] idle_cnt;
  logic idle_rcvd_done, nonidle_seen;
  int tests = 0, fails = 0;
  bit armed = 0, m_done = 0, m_pulse = 0;
  int run = 0;
  logic [LANES*SYM_W-1:0] z = '0, l3 = '0, hi_ff = '0, junk = '1;
  always #5 clk = ~clk;
  idle_rx_detector #(.LANES(LANES), .SYM_W(SYM_W), .TARGET(TARGET), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .det_enable(det_enable), .det_clr(det_clr),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_lane_mask(rx_lane_mask),
    .rx_is_os(rx_is_os), .rx_is_skp(rx_is_skp),
    .idle_cnt(idle_cnt), .idle_rcvd_done(idle_rcvd_done), .nonidle_seen(nonidle_seen));
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask
  function automatic bit sym_is_idle();
    if (rx_is_os || rx_lane_mask == '0) return 1'b0;
    for (int l = 0; l < LANES; l++)
      if (rx_lane_mask[l] && rx_data[l*SYM_W +: SYM_W] != '0) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    m_pulse = 1'b0;
    if (rst) begin
      armed = 0; run = 0; m_done = 0;
    end else if (det_clr) begin
      run = 0; m_done = 0; armed = det_enable;
    end else if (!det_enable) begin
      armed = 0; run = 0; m_done = 0;
    end else if (!armed) begin
      armed = 1;
    end else if (rx_valid && !(SKP_TOL && rx_is_os && rx_is_skp)) begin
      if (sym_is_idle()) begin
        run++;
        if (run >= TARGET) m_done = 1;
      end else begin
        m_pulse = 1;
        if (!m_done) run = 0;
      end
    end
    #1;
    check("cyc_cnt", idle_cnt, (run > TARGET) ? TARGET : run);
    check("cyc_done", idle_rcvd_done, m_done);
    check("cyc_nonidle", nonidle_seen, m_pulse);
  end
  task automatic drv(input bit v, input logic [LANES*SYM_W-1:0] d, input bit os = 0, input bit skp = 0);
    rx_valid = v; rx_data = d; rx_is_os = os; rx_is_skp = skp;
    @(negedge clk);
  endtask
  initial begin
    l3[3*SYM_W +: SYM_W] = 8'h1C;
    for (int l = 4; l < LANES; l++) hi_ff[l*SYM_W +: SYM_W] = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cnt", idle_cnt, 0);
    check("rst_done", idle_rcvd_done, 0);
    check("rst_nonidle", nonidle_seen, 0);
    // T1: arm, then 8 back-to-back Idles
    det_enable = 1'b1;
    drv(1, z);
    check("t1_arm_uncounted", idle_cnt, 0);
    for (int k = 1; k <= 8; k++) begin
      drv(1, z);
      check("t1_cnt", idle_cnt, k);
      check("t1_done", idle_rcvd_done, k == 8);
    end
    repeat (2) drv(1, z);
    check("t1_sat_cnt", idle_cnt, 8);
    check("t1_sat_done", idle_rcvd_done, 1);
    // T2: a non-Idle lane breaks the run
    det_clr = 1'b1; drv(1, z); det_clr = 1'b0;
    check("t2_clr_cnt", idle_cnt, 0);
    check("t2_clr_done", idle_rcvd_done, 0);
    repeat (5) drv(1, z);
    check("t2_cnt5", idle_cnt, 5);
    drv(1, l3);
    check("t2_pulse", nonidle_seen, 1);
    check("t2_reset_cnt", idle_cnt, 0);
    for (int k = 1; k <= 8; k++) begin
      drv(1, z);
      check("t2_pulse_off", nonidle_seen, 0);
      check("t2_done", idle_rcvd_done, k == 8);
    end
    // T3: masked lanes carry garbage, gaps between qsts
    det_clr = 1'b1; drv(0, z); det_clr = 1'b0;
    rx_lane_mask = 16'h000F;
    for (int k = 1; k <= 8; k++) begin
      drv(1, hi_ff);
      drv(0, junk);
      check("t3_cnt", idle_cnt, k);
    end
    check("t3_done", idle_rcvd_done, 1);
    // T4: SKP in the middle of a run
    rx_lane_mask = '1;
    det_clr = 1'b1; drv(0, z); det_clr = 1'b0;
    repeat (4) drv(1, z);
    drv(1, z, 1, 1);
    check("t4_skp_pulse", nonidle_seen, SKP_TOL ? 0 : 1);
    repeat (4) drv(1, z);
    check("t4_cnt", idle_cnt, SKP_TOL ? 8 : 4);
    check("t4_done", idle_rcvd_done, SKP_TOL ? 1 : 0);
    // T5: clear while done, then disable
    det_clr = 1'b1; drv(0, z); det_clr = 1'b0;
    repeat (8) drv(1, z);
    check("t5_done", idle_rcvd_done, 1);
    det_clr = 1'b1; drv(1, z); det_clr = 1'b0;
    check("t5_clr_cnt", idle_cnt, 0);
    check("t5_clr_done", idle_rcvd_done, 0);
    drv(1, z);
    check("t5_counting", idle_cnt, 1);
    det_enable = 1'b0;
    repeat (4) drv(1, z);
    check("t5_off_cnt", idle_cnt, 0);
    check("t5_off_done", idle_rcvd_done, 0);
    det_enable = 1'b1;
    drv(1, z);
    check("t5_rearm", idle_cnt, 0);
    drv(1, z);
    check("t5_rearm_cnt", idle_cnt, 1);
    // T6: reset mid-run, then empty mask
    repeat (5) drv(1, z);
    check("t6_cnt6", idle_cnt, 6);
    rst = 1'b1; drv(1, l3); rst = 1'b0;
    check("t6_rst_cnt", idle_cnt, 0);
    check("t6_rst_done", idle_rcvd_done, 0);
    check("t6_rst_nonidle", nonidle_seen, 0);
    drv(1, z);
    rx_lane_mask = '0;
    drv(1, z);
    check("t6_mask0_pulse", nonidle_seen, 1);
    drv(1, z);
    check("t6_mask0_pulse2", nonidle_seen, 1);
    check("t6_mask0_cnt", idle_cnt, 0);
    // done stays sticky across a non-Idle
    rx_lane_mask = '1;
    repeat (8) drv(1, z);
    drv(1, l3);
    check("sticky_pulse", nonidle_seen, 1);
    check("sticky_done", idle_rcvd_done, 1);
    check("sticky_cnt", idle_cnt, 8);
    drv(0, z);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
